// File: rtl/prbs8_pkg.sv
// prbs8_pkg: definitions shared by the PRBS8 generator and the PRBS8 checker.
//   chk_state_e  : checker acquisition states (SEED, TRACK, LOCKED)
//   lfsr8_next() : one step of the 8-bit Fibonacci LFSR, {x[6:0], ^(x & tap)}
//   PRBS8_TAP_DEF: the tap mask normally used on the link (x^8+x^6+x^5+x^4+1)
package prbs8_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    localparam logic [7:0] PRBS8_TAP_DEF = 8'hB8;

    // Feedback is the parity of the tapped bits, shifted in at the LSB.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] x, input logic [7:0] tap);
        return {x[6:0], ^(x & tap)};
    endfunction

endpackage

// File: rtl/prbs8_checker_if.sv
// prbs8_checker_if: receive-side PRBS8 stream plus checker status.
//   valid, din, tap, err_clr : driven by the source (master)
//   locked, error, err_count : driven by the checker (slave)
// ERR_W must match the ERR_W of the checker the interface is connected to.
interface prbs8_checker_if #(
    parameter int ERR_W = 16
) ();
    logic             valid;
    logic [7:0]       din;
    logic [7:0]       tap;
    logic             err_clr;
    logic             locked;
    logic             error;
    logic [ERR_W-1:0] err_count;

    modport master (
        output valid, din, tap, err_clr,
        input  locked, error, err_count
    );

    modport slave (
        input  valid, din, tap, err_clr,
        output locked, error, err_count
    );
endinterface

// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising checker for an 8-bit Fibonacci LFSR stream.
// Seeds a local predictor from received data, requires LOCK_CNT consecutive
// correct predictions to lock, then free-runs the predictor (flywheel) and
// counts mismatched words; LOSS_CNT consecutive mismatches drop lock.
//
// Ports:
//   clk    : clock, all logic on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : prbs8_checker_if.slave
//              valid/din/tap : received word and tap mask, qualified by valid
//              err_clr       : synchronous clear of err_count (wins over increment)
//              locked        : registered, 1 while in LOCKED
//              error         : registered one-cycle pulse per mismatched locked word
//              err_count     : saturating count of mismatched locked words
//
// state  | meaning
// -------+---------------------------------------------------------------
// SEED   | waiting for a non-zero word to seed the predictor
// TRACK  | predictor seeded, counting consecutive correct predictions
// LOCKED | flywheel prediction, mismatches counted as errors
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    prbs8_checker_if.slave    bus
);

    // Counters are compared against terminal counts of LOCK_CNT-1 / LOSS_CNT-1
    // so the qualifying word itself completes the run.
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0] LOCK_TC = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] LOSS_TC = BW'(LOSS_CNT - 1);

    chk_state_e       state_q, state_d;
    logic [7:0]       pred_q, pred_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             locked_q;
    logic             error_q;
    logic             err_pulse;
    logic [7:0]       nxt_din;
    logic [7:0]       nxt_pred;

    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        good_d    = good_q;
        bad_d     = bad_q;
        err_pulse = 1'b0;
        nxt_din   = lfsr8_next(bus.din, bus.tap);
        nxt_pred  = lfsr8_next(pred_q, bus.tap);

        if (bus.valid) begin
            case (state_q)
                SEED: begin
                    // All-zero is the LFSR lock-up word and never a valid seed.
                    if (bus.din != 8'h00) begin
                        pred_d  = nxt_din;
                        good_d  = '0;
                        state_d = TRACK;
                    end
                end

                TRACK: begin
                    if (bus.din == pred_q) begin
                        pred_d = nxt_din;
                        good_d = good_q + GW'(1);
                        if (good_q == LOCK_TC) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else if (bus.din != 8'h00) begin
                        // Re-seed from the word just received and restart the run.
                        pred_d = nxt_din;
                        good_d = '0;
                    end else begin
                        state_d = SEED;
                    end
                end

                LOCKED: begin
                    // Flywheel: prediction advances from itself, not from din,
                    // so isolated corrupt words do not derail tracking.
                    pred_d = nxt_pred;
                    if (bus.din == pred_q) begin
                        bad_d = '0;
                    end else begin
                        err_pulse = 1'b1;
                        if (bad_q == LOSS_TC) begin
                            state_d = SEED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + BW'(1);
                        end
                    end
                end

                default: begin
                    state_d = SEED;
                end
            endcase
        end

        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = '0;
        end else if (err_pulse && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEED;
            pred_q    <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            err_cnt_q <= err_cnt_d;
            locked_q  <= (state_d == LOCKED);
            error_q   <= err_pulse;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.error     = error_q;
    assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: directed bench for prbs8_checker.
// dut_a: LOCK_CNT=4, LOSS_CNT=3, ERR_W=16 (acquire, single error, loss, relock,
//        zero seed, valid gaps, reset while locked).
// dut_b: LOCK_CNT=4, LOSS_CNT=8, ERR_W=2 (err_count saturation, err_clr vs increment).
// Each step drives one cycle of inputs and pushes the expected outputs to a
// queue; after the clock edge the entry is popped and compared.
module tb_prbs8_checker;

    logic clk;
    logic reset_a;
    logic reset_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        locked;
        logic        error;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    prbs8_checker_if #(.ERR_W(16)) bus_a ();
    prbs8_checker_if #(.ERR_W(2))  bus_b ();

    prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.slave)
    );

    prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(2)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // sel=0 drives dut_a, sel=1 drives dut_b; the other DUT sees valid=0.
    task automatic step(input bit sel, input logic rst, input logic v, input logic [7:0] d,
                        input logic clr, input logic el, input logic ee,
                        input logic [15:0] ec, input string tag);
        exp_t e;
        exp_t got;
        if (sel == 1'b0) begin
            reset_a = rst; bus_a.valid = v; bus_a.din = d; bus_a.err_clr = clr;
            reset_b = 1'b0; bus_b.valid = 1'b0; bus_b.err_clr = 1'b0;
        end else begin
            reset_b = rst; bus_b.valid = v; bus_b.din = d; bus_b.err_clr = clr;
            reset_a = 1'b0; bus_a.valid = 1'b0; bus_a.err_clr = 1'b0;
        end
        e.tag = tag; e.locked = el; e.error = ee; e.cnt = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed none expected 1 entry", tag);
        end else begin
            got = sb.pop_front();
            if (sel == 1'b0) begin
                check({got.tag, ".locked"}, 16'(bus_a.locked), 16'(got.locked));
                check({got.tag, ".error"},  16'(bus_a.error),  16'(got.error));
                check({got.tag, ".cnt"},    bus_a.err_count,   got.cnt);
            end else begin
                check({got.tag, ".locked"}, 16'(bus_b.locked), 16'(got.locked));
                check({got.tag, ".error"},  16'(bus_b.error),  16'(got.error));
                check({got.tag, ".cnt"},    16'(bus_b.err_count), got.cnt);
            end
        end
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        bus_a.valid = 1'b0; bus_a.din = 8'h00; bus_a.tap = 8'hB8; bus_a.err_clr = 1'b0;
        bus_b.valid = 1'b0; bus_b.din = 8'h00; bus_b.tap = 8'hB8; bus_b.err_clr = 1'b0;

        // ---------------- dut_a ----------------
        step(0, 1, 0, 8'h00, 0, 0, 0, 16'd0, "a_rst0");
        step(0, 1, 0, 8'h00, 0, 0, 0, 16'd0, "a_rst1");
        step(0, 0, 1, 8'h00, 0, 0, 0, 16'd0, "a_zero_seed");
        step(0, 0, 1, 8'h00, 0, 0, 0, 16'd0, "a_zero_seed2");
        // 01 seeds, 02..11 are four matches -> locked after 11
        step(0, 0, 1, 8'h01, 0, 0, 0, 16'd0, "a_acq01");
        step(0, 0, 1, 8'h02, 0, 0, 0, 16'd0, "a_acq02");
        step(0, 0, 1, 8'h04, 0, 0, 0, 16'd0, "a_acq04");
        step(0, 0, 1, 8'h08, 0, 0, 0, 16'd0, "a_acq08");
        step(0, 0, 1, 8'h11, 0, 1, 0, 16'd0, "a_acq11");
        // single error: 22 in place of 23, flywheel still predicts 47
        step(0, 0, 1, 8'h22, 0, 1, 1, 16'd1, "a_single_err");
        step(0, 0, 1, 8'h47, 0, 1, 0, 16'd1, "a_after_err");
        // 5-cycle gap with garbage on din
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 8'h5A, 0, 1, 0, 16'd1, "a_gap");
        step(0, 0, 1, 8'h8E, 0, 1, 0, 16'd1, "a_post_gap");
        step(0, 0, 0, 8'h00, 1, 1, 0, 16'd0, "a_clr");
        // loss: three corrupt words (predictions 1C, 38, 71)
        step(0, 0, 1, 8'hFF, 0, 1, 1, 16'd1, "a_loss1");
        step(0, 0, 1, 8'hFF, 0, 1, 1, 16'd2, "a_loss2");
        step(0, 0, 1, 8'hFF, 0, 0, 1, 16'd3, "a_loss3");
        // relock with a TRACK re-seed in between: 71,E2 then 01 re-seeds
        step(0, 0, 1, 8'h71, 0, 0, 0, 16'd3, "a_seed71");
        step(0, 0, 1, 8'hE2, 0, 0, 0, 16'd3, "a_trkE2");
        step(0, 0, 1, 8'h01, 0, 0, 0, 16'd3, "a_reseed01");
        step(0, 0, 1, 8'h02, 0, 0, 0, 16'd3, "a_re02");
        step(0, 0, 1, 8'h04, 0, 0, 0, 16'd3, "a_re04");
        step(0, 0, 1, 8'h08, 0, 0, 0, 16'd3, "a_re08");
        step(0, 0, 1, 8'h11, 0, 1, 0, 16'd3, "a_relock11");
        step(0, 0, 1, 8'h23, 0, 1, 0, 16'd3, "a_lock23");
        // reset while locked
        step(0, 1, 1, 8'h47, 0, 0, 0, 16'd0, "a_rst_locked");
        step(0, 0, 0, 8'h00, 0, 0, 0, 16'd0, "a_idle");

        // ---------------- dut_b ----------------
        step(1, 1, 0, 8'h00, 0, 0, 0, 16'd0, "b_rst");
        step(1, 0, 1, 8'h01, 0, 0, 0, 16'd0, "b_acq01");
        step(1, 0, 1, 8'h02, 0, 0, 0, 16'd0, "b_acq02");
        step(1, 0, 1, 8'h04, 0, 0, 0, 16'd0, "b_acq04");
        step(1, 0, 1, 8'h08, 0, 0, 0, 16'd0, "b_acq08");
        step(1, 0, 1, 8'h11, 0, 1, 0, 16'd0, "b_acq11");
        // five mismatches: count saturates at 3
        step(1, 0, 1, 8'hFF, 0, 1, 1, 16'd1, "b_sat1");
        step(1, 0, 1, 8'hFF, 0, 1, 1, 16'd2, "b_sat2");
        step(1, 0, 1, 8'hFF, 0, 1, 1, 16'd3, "b_sat3");
        step(1, 0, 1, 8'hFF, 0, 1, 1, 16'd3, "b_sat4");
        step(1, 0, 1, 8'hFF, 0, 1, 1, 16'd3, "b_sat5");
        // clear in the same cycle as a mismatch: clear wins, pulse still fires
        step(1, 0, 1, 8'hFF, 1, 1, 1, 16'd0, "b_clr_vs_inc");
        step(1, 0, 0, 8'h00, 1, 1, 0, 16'd0, "b_clr_idle");
        // flywheel advanced 6 times from 23 -> predicts E2
        step(1, 0, 1, 8'hE2, 0, 1, 0, 16'd0, "b_match_E2");
        step(1, 0, 1, 8'hC4, 0, 1, 0, 16'd0, "b_match_C4");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs8_checker.md
# prbs8_checker

Downstream consumer of the 8-bit Fibonacci LFSR generator. Receives one LFSR word per valid cycle and self-synchronises by seeding a local predictor from the received data. Once locked, it tracks the stream with a flywheel predictor and counts word errors. Used as the receive-side integrity checker in PRBS loopback and link tests.

## Interface

- LOCK_CNT, 4: consecutive correct predictions required to declare lock (≥1).
- LOSS_CNT, 3: consecutive mismatches while locked that drop lock (≥1).
- ERR_W, 16: width of the saturating error counter.

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  din/tap qualify this cycle.
- din  in  8  received LFSR word.
- tap  in  8  feedback tap mask; must match the generator's mask.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  registered; 1 while in LOCKED.
- error  out  1  registered one-cycle pulse per mismatched word while locked.
- err_count  out  ERR_W  saturating count of mismatched words while locked.

## Operation

- Next-state function, identical to the generator: next(x) = {x[6:0], ^(x & tap)}. Uses the tap value present on the same valid cycle.
- Internal registers:
  - state ∈ {SEED, TRACK, LOCKED}
  - pred[7:0]
  - good_cnt (counts to LOCK_CNT)
  - bad_cnt (counts to LOSS_CNT)
- Reset values:
  - state=SEED, pred=0, good_cnt=0, bad_cnt=0.
  - locked=0, error=0, err_count=0.
- valid=0: all state holds; error=0.
- SEED, valid=1:
  - din≠0: pred←next(din), good_cnt←0, go TRACK.
  - din=0: stay in SEED (the all-zero word is a lock-up state and is never accepted as a seed).
- TRACK, valid=1:
  - din==pred: pred←next(din), good_cnt++. When good_cnt+1==LOCK_CNT, go LOCKED with bad_cnt←0.
  - din≠pred, din≠0: re-seed with pred←next(din), good_cnt←0, stay in TRACK.
  - din≠pred, din=0: go SEED.
  - No errors are counted in SEED or TRACK.
- LOCKED, valid=1 (flywheel mode):
  - pred←next(pred) regardless of din.
  - Match: bad_cnt←0.
  - Mismatch: error←1, err_count increments (saturating at all-ones), bad_cnt++.
  - When bad_cnt+1==LOSS_CNT: go SEED and clear good_cnt and bad_cnt. The mismatch that causes loss is still counted and pulsed.
- err_clr:
  - Clears err_count to 0 on the next edge.
  - If err_clr and an increment occur in the same cycle, clear wins and err_count=0.
  - err_clr does not affect state.
- tap change while locked is not compensated; the resulting mismatches count as errors.
- reset asserted mid-stream overrides everything: next cycle returns to the reset values.

## Timing

- Every output is registered, with one cycle of latency from the qualifying valid edge.
- locked rises the cycle after the LOCK_CNT-th consecutive matching word is accepted.
- locked falls the cycle after the LOSS_CNT-th consecutive mismatch.
- error is high for exactly one cycle per mismatched locked word. Back-to-back mismatches give back-to-back pulses.
- valid may deassert for any number of cycles without affecting lock, counters, or prediction.
- Throughput is one word per cycle, with no backpressure.

## Structure

- Shared package prbs8_pkg, also imported by the generator side:
  - state enum (SEED, TRACK, LOCKED)
  - function lfsr8_next(x, tap)
- No sub-module. A single always_ff block with combinational next-state logic, roughly 150 lines.

## Test plan

Reference sequence for tap=8'hB8, seed 01: 01,02,04,08,11,23,47.

- Reset: hold reset 2 cycles -> locked=0, error=0, err_count=0. Asserting reset while LOCKED -> locked=0 next cycle.
- Acquire: tap=B8, stream 01,02,04,08,11 on consecutive valids -> 01 seeds; locked=1 the cycle after 11; err_count=0.
- Single error: locked, send 22 in place of 23, then 47 -> one error pulse; err_count=1; flywheel predicts 47, so locked stays 1.
- Loss: locked, three consecutive corrupt words (LOSS_CNT=3) -> three error pulses; err_count=3; locked=0 after the third; state SEED. A fresh good stream relocks after 1+4 words.
- Zero and gaps:
  - din=00 in SEED keeps locked=0 and stays in SEED.
  - Inserting 5-cycle valid=0 gaps mid-stream while locked causes no error and no loss of lock.
- Counter edges (ERR_W=2):
  - Five locked mismatches (LOSS_CNT=8) -> err_count saturates at 3.
  - err_clr in the same cycle as a mismatch -> err_count=0, error still pulses.
